// File: rtl/pacman_mover.sv
// pacman_mover: owns Pac-Man's pixel position, direction and buffered joystick request.
// Ports:
//   clk, rst           clock; asynchronous active-high reset
//   move_tick          one-cycle frame pulse that starts one movement step
//   btn_dir            joystick request {L,R,U,D}; only one-hot values are latched
//   legal_moves        legality mask {L,R,U,D} for the current position/direction
//   xpos, ypos         pixel position of the top-left corner
//   current_direction  one-hot {L,R,U,D}; 0 means stopped
//   row, col           grid cell the sprite is leaving (or sitting in when aligned)
//   aligned            sprite sits exactly on a cell
//   step_done          one-cycle pulse after the position changed
//   tick_overrun       sticky flag: a tick arrived while a previous one was in flight
module pacman_mover #(
    parameter int START_ROW = 0,
    parameter int START_COL = 1,
    parameter int ORIGIN_X  = 150,
    parameter int ORIGIN_Y  = 34,
    parameter int CELL      = 60,
    parameter int STEP      = 4,
    parameter int LEGAL_LAT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_tick,
    input  logic [3:0] btn_dir,
    input  logic [3:0] legal_moves,
    output logic [9:0] xpos,
    output logic [9:0] ypos,
    output logic [3:0] current_direction,
    output logic [2:0] row,
    output logic [2:0] col,
    output logic       aligned,
    output logic       step_done,
    output logic       tick_overrun
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DECIDE, S_STEP} state_t;

    localparam logic [9:0] X0       = 10'(ORIGIN_X + START_COL * CELL);
    localparam logic [9:0] Y0       = 10'(ORIGIN_Y + START_ROW * CELL);
    localparam logic [9:0] STEP_PX  = 10'(STEP);
    localparam logic [5:0] STEP_SUB = 6'(STEP);
    localparam logic [5:0] CELL_SUB = 6'(CELL);
    localparam logic [1:0] LAT      = 2'(LEGAL_LAT);

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [3:0] dir_q, dir_d, pend_q, pend_d;
    logic [2:0] row_q, row_d, col_q, col_d;
    logic [5:0] sub_q, sub_d;
    logic       sd_q, sd_d, ovr_q, ovr_d;

    logic [3:0] opp, legal_eff;
    logic [2:0] row_adv, col_adv;

    // row/col of the cell being approached in the current direction
    assign opp       = {dir_q[2], dir_q[3], dir_q[0], dir_q[1]};
    assign row_adv   = dir_q[1] ? row_q - 3'd1 : dir_q[0] ? row_q + 3'd1 : row_q;
    assign col_adv   = dir_q[3] ? col_q - 3'd1 : dir_q[2] ? col_q + 3'd1 : col_q;
    // moves that would leave the 8x8 grid are never legal
    assign legal_eff = legal_moves & {col_q != 3'd0, col_q != 3'd7, row_q != 3'd0, row_q != 3'd7};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        row_d   = row_q;
        col_d   = col_q;
        sub_d   = sub_q;
        sd_d    = 1'b0;
        ovr_d   = ovr_q | (move_tick && state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (move_tick) begin
                if (sub_q == 6'd0) begin
                    state_d = S_WAIT;
                    cnt_d   = LAT;
                end else begin
                    // mid-cell reversal: re-base on the cell we were heading to
                    if (pend_q != 4'd0 && pend_q == opp) begin
                        dir_d  = pend_q;
                        pend_d = 4'd0;
                        sub_d  = CELL_SUB - sub_q;
                        row_d  = row_adv;
                        col_d  = col_adv;
                    end
                    state_d = S_STEP;
                end
            end
            S_WAIT: begin
                cnt_d   = cnt_q - 2'd1;
                state_d = cnt_q == 2'd1 ? S_DECIDE : S_WAIT;
            end
            S_DECIDE: begin
                if ((pend_q & legal_eff) != 4'd0) begin
                    dir_d  = pend_q;
                    pend_d = 4'd0;
                end else if ((dir_q & legal_eff) == 4'd0) begin
                    dir_d = 4'd0;
                end
                state_d = S_STEP;
            end
            S_STEP: begin
                if (dir_q != 4'd0) begin
                    x_d  = dir_q[3] ? x_q - STEP_PX : dir_q[2] ? x_q + STEP_PX : x_q;
                    y_d  = dir_q[1] ? y_q - STEP_PX : dir_q[0] ? y_q + STEP_PX : y_q;
                    sd_d = 1'b1;
                    if (sub_q + STEP_SUB == CELL_SUB) begin
                        sub_d = 6'd0;
                        row_d = row_adv;
                        col_d = col_adv;
                    end else begin
                        sub_d = sub_q + STEP_SUB;
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // a fresh press this cycle outranks clearing the consumed request
        if ($onehot(btn_dir)) pend_d = btn_dir;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            x_q     <= X0;
            y_q     <= Y0;
            dir_q   <= 4'd0;
            pend_q  <= 4'd0;
            row_q   <= 3'(START_ROW);
            col_q   <= 3'(START_COL);
            sub_q   <= 6'd0;
            sd_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            row_q   <= row_d;
            col_q   <= col_d;
            sub_q   <= sub_d;
            sd_q    <= sd_d;
            ovr_q   <= ovr_d;
        end
    end

    assign xpos              = x_q;
    assign ypos              = y_q;
    assign current_direction = dir_q;
    assign row               = row_q;
    assign col               = col_q;
    assign aligned           = sub_q == 6'd0;
    assign step_done         = sd_q;
    assign tick_overrun      = ovr_q;
endmodule
